// File: rtl/knight_seq_if.sv
// Command/status bundle between a controller and the knight-scanner sequencer.
// Latency: none (wires only).
// Backpressure: none; start is only honoured while the sequencer is idle.
//   master: drives start/stop/pause/div/passes/mode, observes out/up/busy/step/done
//   slave : the sequencer side
interface knight_seq_if #(
    parameter int WIDTH = 8,
    parameter int DIVW  = 16
);
    logic             start;
    logic             stop;
    logic             pause;
    logic [DIVW-1:0]  div;
    logic [3:0]       passes;
    logic [1:0]       mode;
    logic [WIDTH-1:0] out;
    logic             up;
    logic             busy;
    logic             step;
    logic             done;

    modport master (
        output start, stop, pause, div, passes, mode,
        input  out, up, busy, step, done
    );

    modport slave (
        input  start, stop, pause, div, passes, mode,
        output out, up, busy, step, done
    );
endinterface

// File: rtl/knight_seq.sv
// Knight-scanner sequencer: prescaled position engine with bounce/wrap/fill display modes.
// Latency: all outputs registered; first step div+1 cycles after start is accepted.
// Backpressure: pause freezes the engine, stop aborts to idle; start ignored while running.
//   ports: ck, res (sync active-high), bus (knight_seq_if.slave: start/stop/pause/div/
//          passes/mode in; out/up/busy/step/done out)
module knight_seq #(
    parameter int WIDTH = 8,
    parameter int DIVW  = 16
) (
    input  logic        ck,
    input  logic        res,
    knight_seq_if.slave bus
);
    localparam int             PW   = $clog2(WIDTH);
    localparam logic [PW-1:0]  LAST = PW'(WIDTH - 1);
    localparam logic [1:0]     MODE_WRAP = 2'd1;
    localparam logic [1:0]     MODE_FILL = 2'd2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_n;
    logic [PW-1:0]    pos_q, pos_n;
    logic             up_q, up_n;
    logic [DIVW-1:0]  cnt_q, cnt_n;
    logic [DIVW-1:0]  div_q, div_n;
    logic [3:0]       pcnt_q, pcnt_n;
    logic [3:0]       passes_q, passes_n;
    logic [1:0]       mode_q, mode_n;
    logic [WIDTH-1:0] out_q, out_n;
    logic             busy_q;
    logic             step_q, step_n;
    logic             done_q, done_n;
    logic             pass_end;

    always_ff @(posedge ck) begin
        if (res) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            up_q     <= 1'b1;
            cnt_q    <= '0;
            div_q    <= '0;
            pcnt_q   <= '0;
            passes_q <= '0;
            mode_q   <= '0;
            out_q    <= WIDTH'(1);
            busy_q   <= 1'b0;
            step_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            pos_q    <= pos_n;
            up_q     <= up_n;
            cnt_q    <= cnt_n;
            div_q    <= div_n;
            pcnt_q   <= pcnt_n;
            passes_q <= passes_n;
            mode_q   <= mode_n;
            out_q    <= out_n;
            busy_q   <= (state_n == RUN);
            step_q   <= step_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        pos_n    = pos_q;
        up_n     = up_q;
        cnt_n    = cnt_q;
        div_n    = div_q;
        pcnt_n   = pcnt_q;
        passes_n = passes_q;
        mode_n   = mode_q;
        step_n   = 1'b0;
        done_n   = 1'b0;
        pass_end = 1'b0;
        out_n    = '0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_n  = RUN;
                    div_n    = bus.div;
                    passes_n = bus.passes;
                    mode_n   = bus.mode;
                    cnt_n    = '0;
                    pcnt_n   = '0;
                    pos_n    = '0;
                    up_n     = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    // abort wins over pause and over a step due this cycle
                    state_n = IDLE;
                    pos_n   = '0;
                    up_n    = 1'b1;
                    cnt_n   = '0;
                end else if (!bus.pause) begin
                    if (cnt_q == div_q) begin
                        cnt_n  = '0;
                        step_n = 1'b1;
                        if (mode_q == MODE_WRAP) begin
                            up_n = 1'b1;
                            if (pos_q == LAST) begin
                                pos_n    = '0;
                                pass_end = 1'b1;
                            end else begin
                                pos_n = pos_q + 1'b1;
                            end
                        end else if (up_q) begin
                            // direction flips in the same update that reaches the end
                            pos_n = pos_q + 1'b1;
                            if (pos_q == LAST - 1'b1) up_n = 1'b0;
                        end else begin
                            pos_n = pos_q - 1'b1;
                            if (pos_q == PW'(1)) begin
                                up_n     = 1'b1;
                                pass_end = 1'b1;
                            end
                        end
                        if (pass_end) begin
                            if (passes_q != 4'd0 && (pcnt_q + 4'd1) == passes_q) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end else begin
                                pcnt_n = pcnt_q + 4'd1;
                            end
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // mode 3 falls through to one-hot, same as bounce
        for (int i = 0; i < WIDTH; i++) begin
            if (mode_n == MODE_FILL) out_n[i] = (i <= int'(pos_n));
            else                     out_n[i] = (i == int'(pos_n));
        end
    end

    assign bus.out  = out_q;
    assign bus.up   = up_q;
    assign bus.busy = busy_q;
    assign bus.step = step_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_knight_seq.sv
// Directed bench for knight_seq: reset, bounce/wrap/fill runs, pause/stop/res mid-run.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: n/a; global watchdog bounds the run.
module tb_knight_seq;
    logic ck;
    logic res;
    int   checks;
    int   errors;

    knight_seq_if #(.WIDTH(8), .DIVW(16)) bus ();

    knight_seq #(.WIDTH(8), .DIVW(16)) dut (
        .ck  (ck),
        .res (res),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic start_run(input logic [15:0] d, input logic [3:0] p, input logic [1:0] m);
        bus.start  = 1'b1;
        bus.div    = d;
        bus.passes = p;
        bus.mode   = m;
        tick();
        bus.start  = 1'b0;
        // latched values must be ignored after start
        bus.div    = 16'd7;
        bus.passes = 4'd9;
        bus.mode   = 2'd3;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out"},  32'(bus.out), 32'h01);
        chk({tag, "_up"},   32'(bus.up),  32'd1);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_step"}, 32'(bus.step), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    logic [7:0] bounce_tab [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] fill_tab   [14] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                    8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
    logic [7:0] wrap_tab   [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int steps;
        int done_cyc;
        checks = 0;
        errors = 0;

        // reset with random inputs
        res = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.start  = 1'($urandom);
            bus.stop   = 1'($urandom);
            bus.pause  = 1'($urandom);
            bus.div    = 16'($urandom);
            bus.passes = 4'($urandom);
            bus.mode   = 2'($urandom);
            tick();
        end
        res = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.pause = 1'b0;
        chk_idle("rst");

        // bounce, div=0, passes=1
        start_run(16'd0, 4'd1, 2'd0);
        chk("b_busy0", 32'(bus.busy), 32'd1);
        chk("b_out0",  32'(bus.out),  32'h01);
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk("b_out",  32'(bus.out),  32'(bounce_tab[i-1]));
            chk("b_step", 32'(bus.step), 32'd1);
            chk("b_up",   32'(bus.up),   32'((i < 7) || (i == 14)));
            chk("b_done", 32'(bus.done), 32'(i == 14));
            chk("b_busy", 32'(bus.busy), 32'(i != 14));
        end
        tick();
        chk("b_after_done", 32'(bus.done), 32'd0);
        chk("b_after_step", 32'(bus.step), 32'd0);

        // wrap, div=2, passes=2: start accepted on first idle cycle after done
        start_run(16'd2, 4'd2, 2'd1);
        chk("w_busy0", 32'(bus.busy), 32'd1);
        steps    = 0;
        done_cyc = 0;
        for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
            tick();
            chk("w_step", 32'(bus.step), 32'(c % 3 == 0));
            chk("w_done", 32'(bus.done), 32'(c == 48));
            chk("w_up",   32'(bus.up),   32'd1);
            if (bus.step) begin
                chk("w_out", 32'(bus.out), 32'(wrap_tab[steps % 8]));
                steps++;
            end
            if (bus.done) done_cyc = c;
        end
        chk("w_done_cyc", 32'(done_cyc), 32'd48);
        chk("w_steps",    32'(steps),    32'd16);
        chk("w_busy_end", 32'(bus.busy), 32'd0);
        tick();

        // fill, div=0, passes=1
        start_run(16'd0, 4'd1, 2'd2);
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk("f_out",  32'(bus.out),  32'(fill_tab[i-1]));
            chk("f_done", 32'(bus.done), 32'(i == 14));
        end
        tick();
        chk_idle("f_end");

        // continuous, div=1: pause, resume cadence, then stop at pos 5
        start_run(16'd1, 4'd0, 2'd0);
        tick();
        chk("p_step_a", 32'(bus.step), 32'd0);
        tick();
        chk("p_step_b", 32'(bus.step), 32'd1);
        chk("p_out_b",  32'(bus.out),  32'h02);
        bus.pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("p_hold_step", 32'(bus.step), 32'd0);
            chk("p_hold_out",  32'(bus.out),  32'h02);
        end
        bus.pause = 1'b0;
        tick();
        chk("p_res_a", 32'(bus.step), 32'd0);
        tick();
        chk("p_res_b", 32'(bus.step), 32'd1);
        chk("p_res_out", 32'(bus.out), 32'h04);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("p_cad", 32'(bus.step), 32'(i % 2 == 0));
        end
        chk("p_pos5", 32'(bus.out), 32'h20);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk_idle("stop");
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("ss_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("ss_busy2", 32'(bus.busy), 32'd0);

        // res mid-run at pos 3
        start_run(16'd0, 4'd0, 2'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("r_pos3", 32'(bus.out), 32'h08);
        res = 1'b1;
        tick();
        res = 1'b0;
        chk_idle("r_mid");
        start_run(16'd0, 4'd1, 2'd0);
        chk("r_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("r_step", 32'(bus.step), 32'd1);
        chk("r_out",  32'(bus.out),  32'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/knight_seq.md
# knight_seq

Sequencer for the knight-scanner LED datapath: owns the scan position and direction, paces steps with a programmable prescaler, and runs a requested number of sweeps before returning to idle. A start/stop command interface sits in front of it, and it drives the 8-LED output bus directly. Three display modes share one position engine: bounce (classic knight), wrap and fill (bar).

## Interface
- WIDTH, 8, number of LEDs / scan positions (≥2)
- DIVW, 16, prescaler width
- ck  in  1  clock, all state on rising edge
- res  in  1  reset, synchronous, active-high
- start  in  1  start request, sampled in IDLE only
- stop  in  1  abort request, sampled every cycle
- pause  in  1  level; freezes prescaler and position while in RUN
- div  in  DIVW  step period minus one, latched at start
- passes  in  4  number of passes to run, latched at start; 0 = continuous
- mode  in  2  0 bounce, 1 wrap, 2 fill, 3 reserved (behaves as bounce); latched at start
- out  out  WIDTH  LED pattern
- up  out  1  current scan direction (1 = toward MSB)
- busy  out  1  high while in RUN
- step  out  1  one-cycle strobe, coincident with each new out value
- done  out  1  one-cycle strobe on completion of the final pass

## Operation
- States: IDLE, RUN. Internal: pos (0..WIDTH-1), cnt (DIVW bits), pcnt (4 bits), latched div/passes/mode.
- Reset (res=1, overrides all inputs): state IDLE, pos=0, up=1, cnt=0, pcnt=0, out=...0001, busy=0, step=0, done=0.
- IDLE: out shows pos 0; start=1 and stop=0 → RUN; latch div/passes/mode; cnt=0, pcnt=0, pos=0, up=1. start with stop in the same cycle → stay IDLE.
- RUN, stop=1: → IDLE, pos=0, up=1, cnt=0; no done and no step that cycle. stop has priority over pause and over a due step.
- RUN, pause=1 (stop=0): all state held; step=0.
- RUN otherwise: if cnt==div → cnt=0 and a step occurs; else cnt+1.
- Step, bounce/fill: up=1 → pos+1; on arriving at WIDTH-1, up=0 in the same update. up=0 → pos-1; on arriving at 0, up=1 and pass completes. A pass is 2·(WIDTH-1) steps (14 for WIDTH=8).
- Step, wrap: pos+1, with WIDTH-1 → 0 completing a pass; up constantly 1. A pass is WIDTH steps.
- Pass completion: if passes≠0 and pcnt+1==passes → IDLE, done=1 in the same cycle as that step; else pcnt+1 (mod 16). With passes=0, pcnt wraps freely and the block runs until stop.
- out: bounce/wrap = one-hot 1<<pos; fill = thermometer with bits [pos:0] set.
- start while in RUN is ignored; div/passes/mode changes while in RUN have no effect.

## Timing
- All outputs are registered.
- start sampled at edge k → busy=1 after edge k. With no pause, the first step is visible after edge k+div+1, and subsequent steps follow every div+1 cycles. div=0 gives one step per cycle.
- step and the new out/up value appear in the same cycle. done, the final step and busy falling all occur in the same cycle; the next cycle has done=0 and step=0.
- A new start is accepted in the cycle after done, i.e. on the first IDLE cycle.
- pause asserted at an edge holds cnt exactly. The step resumes div+1−cnt cycles after pause deasserts.
- res mid-run takes effect on the next edge, with reset values as listed above; no done.

## Test plan
- Reset: hold res 2 cycles with random inputs → out=00000001, up=1, busy=0, step=0, done=0.
- Bounce, div=0, passes=1: out steps 02,04,…,80,40,…,01 on 14 consecutive cycles; up falls with out=80; done=1 with final 01; busy=0 after.
- Wrap, div=2, passes=2: a step every 3 cycles, 16 steps, 80→01 twice, up stays 1, and done occurs 48 cycles after busy rises.
- Fill, div=0, passes=1: out 03,07,…,FF,7F,…,01, then done.
- Mid-run events, passes=0, div=1: pause for 5 cycles → out and step frozen, then the cadence resumes; stop at pos 5 → out=01, busy=0 next cycle, no done. stop and start in the same IDLE cycle → stays IDLE.
- res asserted at pos 3 in RUN → all reset values after the next edge; start is then accepted normally.
